// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick scheduler.
// Holds the FSM state type, the reset divisor and the divisor clamp.
package tick_sched_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int unsigned DIV_DEFAULT_C = 3;

   // A zero divisor behaves as one: tick every cycle.
   function automatic logic [31:0] clamp_div(
      input logic [31:0] d
   );
      return (d == 32'd0) ? 32'd1 : d;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the caller owns the pointer.
// Ports: req, en (grant enable), ptr in; one-hot gnt, next_ptr out.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic            en,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   next_ptr
);

   logic found;

   // Scan from ptr upward (mod NREQ); first hit wins.
   always_comb begin
      gnt      = '0;
      next_ptr = ptr;
      found    = 1'b0;
      for (int k = 0; k < int'(NREQ); k++) begin
         int idx;
         idx = (int'(ptr) + k) % int'(NREQ);
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            next_ptr = PW'((idx + 1) % int'(NREQ));
         end
      end
   end

endmodule

// File: rtl/tick_scheduler.sv
// Divide-by-N tick generator with round-robin tick grant.
// Ports: clk, reset_n, en, div_val/div_valid/div_ready, req,
//   tick, gnt, busy; miss_cnt when TICK_SCHED_MISS_EN is defined.
module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned DIVW        = 8,
   parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_C
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            en,
   input  logic [DIVW-1:0] div_val,
   input  logic            div_valid,
   output logic            div_ready,
   input  logic [NREQ-1:0] req,
   output logic            tick,
   output logic [NREQ-1:0] gnt,
`ifdef TICK_SCHED_MISS_EN
   output logic [15:0]     miss_cnt,
`endif
   output logic            busy
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          state;
   state_t          state_nxt;
   logic [DIVW-1:0] cnt;
   logic [DIVW-1:0] div;
   logic [DIVW-1:0] pend_div;
   logic            pend_vld;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   next_ptr;
   logic [DIVW-1:0] div_in;
   logic            hs;
   logic            wrap;

   // div is always stored clamped, so div-1 never underflows.
   assign div_in    = DIVW'(clamp_div(32'(div_val)));
   assign div_ready = !pend_vld;
   assign hs        = div_valid && div_ready;
   assign wrap      = (cnt == div - DIVW'(1));

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req      (req),
      .en       (tick),
      .ptr      (rr_ptr),
      .gnt      (gnt),
      .next_ptr (next_ptr)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      tick      = 1'b0;
      unique case (state)
         IDLE: begin
            if (en) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            tick = (cnt == '0);
            if (!en) state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         div      <= DIVW'(clamp_div(32'(DIV_DEFAULT)));
         pend_div <= '0;
         pend_vld <= 1'b0;
         rr_ptr   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (hs) div <= div_in;
            end
            RUN: begin
               if (!en) begin
                  // Partial period dropped; pending divisor lands now.
                  cnt <= '0;
                  if (pend_vld) begin
                     div      <= pend_div;
                     pend_vld <= 1'b0;
                  end else if (hs) begin
                     div <= div_in;
                  end
               end else begin
                  cnt <= wrap ? '0 : cnt + DIVW'(1);
                  if (wrap && pend_vld) begin
                     div      <= pend_div;
                     pend_vld <= 1'b0;
                  end
                  // hs implies !pend_vld, so no clash with the wrap.
                  if (hs) begin
                     pend_div <= div_in;
                     pend_vld <= 1'b1;
                  end
               end
            end
         endcase
         if (|gnt) rr_ptr <= next_ptr;
      end
   end

`ifdef TICK_SCHED_MISS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         miss_cnt <= '0;
      end else if (tick && (req == '0)
                   && (miss_cnt != 16'hFFFF)) begin
         miss_cnt <= miss_cnt + 16'd1;
      end
   end
`endif

endmodule
